// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared element, row and matrix types for the mat_mul operand path
package mat_pkg;

    localparam int W_IN = 8;
    localparam int N    = 8;

    typedef logic signed [W_IN-1:0] elem_t;
    typedef elem_t [N-1:0]          row_t;
    typedef row_t  [N-1:0]          matrix_t;

    typedef enum logic {
        LOAD_A = 1'b0,
        LOAD_B = 1'b1
    } load_state_e;

endpackage

// File: rtl/mat_operand_loader_if.sv
// rtl/mat_operand_loader_if.sv - row-beat stream into the operand loader
interface mat_operand_loader_if #(
    parameter int W_IN = mat_pkg::W_IN,
    parameter int N    = mat_pkg::N
);
    logic                             s_valid;
    logic                             s_ready;
    logic                             s_first;
    logic signed [N-1:0][W_IN-1:0]    s_row;

    modport master (output s_valid, output s_first, output s_row, input s_ready);
    modport slave  (input s_valid, input s_first, input s_row, output s_ready);
endinterface

// File: rtl/mat_operand_loader.sv
// rtl/mat_operand_loader.sv - stages N rows of A then N rows of B, publishes the pair
// to mat_mul with a one-cycle valid_out; the published bank is separate from staging.
module mat_operand_loader
    import mat_pkg::*;
#(
    parameter int W_IN = mat_pkg::W_IN,
    parameter int N    = mat_pkg::N
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cen,
    mat_operand_loader_if.slave                  s,
    output logic                                 valid_out,
    output logic signed [N-1:0][N-1:0][W_IN-1:0] matrix_1,
    output logic signed [N-1:0][N-1:0][W_IN-1:0] matrix_2,
    output logic                                 err,
    output logic                                 busy
);

    localparam int             CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef logic signed [N-1:0][W_IN-1:0] lrow_t;
    typedef lrow_t [N-1:0]                 lmat_t;

    load_state_e   state, state_n;
    logic [CW-1:0] row_cnt, row_cnt_n;
    lmat_t         stage_a, stage_b;

    logic          accept;
    logic          wr_a, wr_b, publish, set_err;
    logic [CW-1:0] wr_idx;

    // No backpressure beyond cen: publishing never collides with staging.
    assign s.s_ready = cen;
    assign accept    = s.s_valid && cen;
    assign busy      = (state == LOAD_B) || (row_cnt != '0);

    always_comb begin
        state_n   = state;
        row_cnt_n = row_cnt;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        publish   = 1'b0;
        set_err   = 1'b0;
        wr_idx    = row_cnt;
        if (accept) begin
            if (s.s_first && busy) begin
                // Unexpected frame start: drop the partial frame, restart on this beat.
                set_err   = 1'b1;
                wr_a      = 1'b1;
                wr_idx    = '0;
                state_n   = LOAD_A;
                row_cnt_n = CW'(1);
            end else begin
                unique case (state)
                    LOAD_A: begin
                        wr_a = 1'b1;
                        if (row_cnt == LAST) begin
                            state_n   = LOAD_B;
                            row_cnt_n = '0;
                        end else begin
                            row_cnt_n = row_cnt + CW'(1);
                        end
                    end
                    LOAD_B: begin
                        wr_b = 1'b1;
                        if (row_cnt == LAST) begin
                            publish   = 1'b1;
                            state_n   = LOAD_A;
                            row_cnt_n = '0;
                        end else begin
                            row_cnt_n = row_cnt + CW'(1);
                        end
                    end
                    default: state_n = LOAD_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD_A;
            row_cnt <= '0;
        end else begin
            state   <= state_n;
            row_cnt <= row_cnt_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_a   <= '0;
            stage_b   <= '0;
            matrix_1  <= '0;
            matrix_2  <= '0;
            valid_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid_out <= publish;
            if (set_err) begin
                err <= 1'b1;
            end
            if (wr_a) begin
                stage_a[wr_idx] <= s.s_row;
            end
            if (wr_b) begin
                stage_b[wr_idx] <= s.s_row;
            end
            if (publish) begin
                // The last B row bypasses staging so the pair is published on its own edge.
                matrix_1 <= stage_a;
                for (int r = 0; r < N; r++) begin
                    matrix_2[r] <= (r == N - 1) ? s.s_row : stage_b[r];
                end
            end
        end
    end

endmodule
